// File: rtl/fifo_demuxn.sv
// Paired data/select demultiplexer with independent input FIFOs and one shared output register.

// fifo_demuxn_fifo: DEPTH-entry circular buffer with occupancy count.
// Latency: push visible at head one edge later; head is a combinational read of the RAM.
// Backpressure: full when count == DEPTH; the caller must not push when full or pop when empty.
module fifo_demuxn_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head  = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
endmodule

// fifo_demuxn: pairs k-th data word with k-th select and presents it on a shared bus to one channel.
// Latency: two edges from acceptance into an empty block to out_valid; full rate when target is ready.
// Backpressure: in_ready/select_ready reflect FIFO space only; a stalled target holds the register.
module fifo_demuxn #(
    parameter int INPUT_WIDTH  = 32,
    parameter int NUM_OUTPUTS  = 4,
    parameter int SELECT_WIDTH = 2,
    parameter int DEPTH        = 4,
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INPUT_WIDTH-1:0]  in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SELECT_WIDTH-1:0] select,
    input  logic                    select_valid,
    output logic                    select_ready,
    output logic [INPUT_WIDTH-1:0]  out,
    output logic [NUM_OUTPUTS-1:0]  out_valid,
    input  logic [NUM_OUTPUTS-1:0]  out_ready,
    output logic                    drop,
    output logic [CW-1:0]           in_count,
    output logic [CW-1:0]           select_count
);
    localparam logic [SELECT_WIDTH:0] NUM_OUT_W = (SELECT_WIDTH + 1)'(NUM_OUTPUTS);

    logic [INPUT_WIDTH-1:0]  d_head;
    logic                    d_full;
    logic                    d_empty;
    logic [SELECT_WIDTH-1:0] s_head;
    logic                    s_full;
    logic                    s_empty;

    logic                    pair_avail;
    logic                    sel_ok;
    logic                    handshake;
    logic                    reg_free;
    logic                    load;
    logic                    discard;
    logic                    pop;

    logic [INPUT_WIDTH-1:0]  dat_r;
    logic [SELECT_WIDTH-1:0] tgt_r;
    logic                    vld_r;
    logic                    drop_r;

    fifo_demuxn_fifo #(.W(INPUT_WIDTH), .DEPTH(DEPTH)) u_data_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (in_valid && in_ready),
        .push_dat (in),
        .pop      (pop),
        .head     (d_head),
        .count    (in_count),
        .full     (d_full),
        .empty    (d_empty)
    );

    fifo_demuxn_fifo #(.W(SELECT_WIDTH), .DEPTH(DEPTH)) u_select_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (select_valid && select_ready),
        .push_dat (select),
        .pop      (pop),
        .head     (s_head),
        .count    (select_count),
        .full     (s_full),
        .empty    (s_empty)
    );

    assign in_ready     = !d_full;
    assign select_ready = !s_full;

    // Out-of-range pairs are discarded without waiting for the output register.
    assign pair_avail = !d_empty && !s_empty;
    assign sel_ok     = ({1'b0, s_head} < NUM_OUT_W);
    assign handshake  = |(out_valid & out_ready);
    assign reg_free   = !vld_r || handshake;
    assign load       = pair_avail && sel_ok && reg_free;
    assign discard    = pair_avail && !sel_ok;
    assign pop        = load || discard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_r  <= '0;
            tgt_r  <= '0;
            vld_r  <= 1'b0;
            drop_r <= 1'b0;
        end else begin
            drop_r <= discard;
            if (load) begin
                dat_r <= d_head;
                tgt_r <= s_head;
                vld_r <= 1'b1;
            end else if (handshake) begin
                vld_r <= 1'b0;
            end
        end
    end

    always_comb begin
        out_valid = '0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            out_valid[k] = vld_r && (tgt_r == SELECT_WIDTH'(k));
        end
    end

    assign out  = dat_r;
    assign drop = drop_r;
endmodule

// File: tb/tb_fifo_demuxn.sv
// Directed and randomized checks of fifo_demuxn against a pairing/ordering reference model.
module tb_fifo_demuxn;
    localparam int DEPTH = 4;
    localparam int NOUT  = 4;

    logic        clk;
    logic        rst;

    logic [31:0] in;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  select;
    logic        select_valid;
    logic        select_ready;
    logic [31:0] out;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic        drop;
    logic [2:0]  in_count;
    logic [2:0]  select_count;

    logic [31:0] b_in;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [1:0]  b_select;
    logic        b_select_valid;
    logic        b_select_ready;
    logic [31:0] b_out;
    logic [2:0]  b_out_valid;
    logic [2:0]  b_out_ready;
    logic        b_drop;
    logic [2:0]  b_in_count;
    logic [2:0]  b_select_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] dq [$];
    logic [1:0]  sq [$];
    logic [33:0] exp_q [$];
    int          n_drop     = 0;
    int          n_drop_exp = 0;
    logic        hold = 1'b0;
    logic [31:0] pout;
    logic [3:0]  pov;

    fifo_demuxn #(.INPUT_WIDTH(32), .NUM_OUTPUTS(4), .SELECT_WIDTH(2), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in(in), .in_valid(in_valid), .in_ready(in_ready),
        .select(select), .select_valid(select_valid), .select_ready(select_ready),
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .drop(drop), .in_count(in_count), .select_count(select_count)
    );

    fifo_demuxn #(.INPUT_WIDTH(32), .NUM_OUTPUTS(3), .SELECT_WIDTH(2), .DEPTH(DEPTH)) dut3 (
        .clk(clk), .rst(rst),
        .in(b_in), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .select(b_select), .select_valid(b_select_valid), .select_ready(b_select_ready),
        .out(b_out), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .drop(b_drop), .in_count(b_in_count), .select_count(b_select_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: score the handshake about to happen, record accepted inputs, advance.
    task automatic tick();
        logic        hs;
        logic [33:0] e;
        logic [31:0] d;
        logic [1:0]  s;
        hs = |(out_valid & out_ready);
        if (hs) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_out observed=%0h expected=none", out);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_dat", out, e[31:0]);
                chk("out_tgt", out_valid, 4'b0001 << e[33:32]);
            end
        end
        hold = (out_valid != 0) && !hs;
        pout = out;
        pov  = out_valid;
        if (in_valid && in_ready)         dq.push_back(in);
        if (select_valid && select_ready) sq.push_back(select);
        while (dq.size() != 0 && sq.size() != 0) begin
            d = dq.pop_front();
            s = sq.pop_front();
            if (int'(s) < NOUT) exp_q.push_back({s, d});
            else                n_drop_exp++;
        end
        @(posedge clk);
        #1;
        if (drop) n_drop++;
        if (hold) begin
            chk("stable_dat", out, pout);
            chk("stable_vld", out_valid, pov);
        end
        chk("in_ready_rule", in_ready, in_count != 3'(DEPTH));
        chk("select_ready_rule", select_ready, select_count != 3'(DEPTH));
        chk("onehot", $countones(out_valid) <= 1, 1);
    endtask

    task automatic reset_state_chk(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_select_ready"}, select_ready, 1);
        chk({tag, "_in_count"}, in_count, 0);
        chk({tag, "_select_count"}, select_count, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out"}, out, 0);
        chk({tag, "_drop"}, drop, 0);
    endtask

    initial begin
        logic [31:0] d_tbl [4];
        logic [1:0]  s_tbl [4];
        logic [3:0]  ov_tbl [6];
        logic [31:0] p0;

        rst = 1'b1;
        in = '0; in_valid = 0; select = '0; select_valid = 0; out_ready = '0;
        b_in = '0; b_in_valid = 0; b_select = '0; b_select_valid = 0; b_out_ready = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        reset_state_chk("rst");
        chk("rst_b_out_valid", b_out_valid, 0);
        chk("rst_b_drop", b_drop, 0);
        rst = 1'b0;

        // Single pair, two-edge latency.
        in = 32'hA5A5_0001; in_valid = 1; select = 2; select_valid = 1; out_ready = 4'b1111;
        tick();
        in_valid = 0; select_valid = 0;
        chk("t1_ov_edge1", out_valid, 4'b0000);
        chk("t1_in_count_edge1", in_count, 1);
        chk("t1_sel_count_edge1", select_count, 1);
        tick();
        chk("t1_ov_edge2", out_valid, 4'b0100);
        chk("t1_out_edge2", out, 32'hA5A5_0001);
        chk("t1_in_count_edge2", in_count, 0);
        chk("t1_sel_count_edge2", select_count, 0);
        tick();
        chk("t1_ov_edge3", out_valid, 4'b0000);

        // Data first, selects afterwards.
        s_tbl[0] = 0; s_tbl[1] = 1; s_tbl[2] = 3; s_tbl[3] = 2;
        ov_tbl[0] = 4'b0000; ov_tbl[1] = 4'b0001; ov_tbl[2] = 4'b0010;
        ov_tbl[3] = 4'b1000; ov_tbl[4] = 4'b0100; ov_tbl[5] = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            d_tbl[i] = $urandom;
            in = d_tbl[i]; in_valid = 1;
            tick();
        end
        in_valid = 0;
        chk("t2_in_ready_full", in_ready, 0);
        chk("t2_in_count_full", in_count, 4);
        chk("t2_ov_nosel", out_valid, 0);
        for (int i = 0; i < 6; i++) begin
            select_valid = (i < 4);
            select = s_tbl[i % 4];
            tick();
            chk("t2_ov_seq", out_valid, ov_tbl[i]);
            if (i >= 1 && i <= 4) chk("t2_out_seq", out, d_tbl[i - 1]);
        end
        select_valid = 0;

        // Stalled target channel fills both FIFOs, then drains one per cycle.
        out_ready = 4'b1101;
        in_valid = 1; select_valid = 1; select = 1;
        p0 = 32'h0;
        for (int i = 0; i < 7; i++) begin
            in = $urandom;
            if (i == 0) p0 = in;
            tick();
        end
        in_valid = 0; select_valid = 0;
        chk("t3_ov_held", out_valid, 4'b0010);
        chk("t3_out_held", out, p0);
        chk("t3_in_count", in_count, DEPTH);
        chk("t3_sel_count", select_count, DEPTH);
        chk("t3_in_ready", in_ready, 0);
        out_ready = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            chk("t3_drain_ov", out_valid, 4'b0010);
            tick();
        end
        chk("t3_drained", out_valid, 4'b0000);

        // Continuous stream of 3*DEPTH pairs with pointer wrap.
        for (int k = 1; k <= 14; k++) begin
            in_valid = (k <= 3 * DEPTH); select_valid = (k <= 3 * DEPTH);
            in = $urandom; select = 2'((k - 1) % 4);
            tick();
            if (k >= 2 && k <= 3 * DEPTH + 1) chk("t4_stream_ov", out_valid, 4'b0001 << ((k - 2) % 4));
        end
        in_valid = 0; select_valid = 0;
        chk("t4_stream_end", out_valid, 0);
        chk("t4_exp_empty", exp_q.size(), 0);

        // Out-of-range select on the three-channel instance.
        b_in = 32'hDEAD; b_select = 3; b_in_valid = 1; b_select_valid = 1;
        tick();
        b_in = 32'hBEEF; b_select = 0;
        tick();
        b_in_valid = 0; b_select_valid = 0;
        chk("t6_drop_pulse", b_drop, 1);
        chk("t6_ov_dropped", b_out_valid, 0);
        tick();
        chk("t6_drop_end", b_drop, 0);
        chk("t6_ov_next", b_out_valid, 3'b001);
        chk("t6_out_next", b_out, 32'hBEEF);
        tick();
        chk("t6_ov_done", b_out_valid, 0);

        // Reset while pairs are buffered and the register is valid.
        out_ready = 4'b0000;
        in_valid = 1; select_valid = 1; select = 1;
        for (int i = 0; i < 4; i++) begin
            in = $urandom;
            tick();
        end
        in_valid = 0; select_valid = 0;
        tick();
        chk("t5_pre_count", in_count, 3);
        chk("t5_pre_ov", out_valid, 4'b0010);
        #2 rst = 1'b1;
        #1;
        reset_state_chk("t5_async");
        dq.delete(); sq.delete(); exp_q.delete(); hold = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 4'b1111;
        in = 32'h1234_5678; in_valid = 1; select = 3; select_valid = 1;
        tick();
        in_valid = 0; select_valid = 0;
        chk("t5_post_ov1", out_valid, 0);
        tick();
        chk("t5_post_ov2", out_valid, 4'b1000);
        chk("t5_post_out", out, 32'h1234_5678);
        tick();

        // Randomized traffic against the pairing model.
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in = $urandom;
            select_valid = 1'($urandom_range(0, 1));
            select = 2'($urandom_range(0, 3));
            out_ready = 4'($urandom);
            tick();
        end
        in_valid = 0; select_valid = 0; out_ready = 4'b1111;
        for (int i = 0; i < 12; i++) tick();
        chk("rand_all_delivered", exp_q.size(), 0);
        chk("rand_ov_idle", out_valid, 0);
        chk("rand_in_leftover", in_count, dq.size());
        chk("rand_sel_leftover", select_count, sq.size());
        chk("rand_drops", n_drop, n_drop_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
